mouse_cursor_painter: RTL and testbench
=======================================

Name: mouse_cursor_painter

Overview:
- Successor to the single-pixel mouse-to-panel writer. Overlays an S×S cursor on the LED-panel frame memory, which is split across NUM_BANKS row-banks.
- Saves the pixels under the cursor and restores them when the cursor moves.
- Adds paint (left button) and erase (right button) modes that commit colour permanently.
- Sits between the PS/2 mouse decoder and the panel frame-buffer RAMs.

Parameters:
- X_MAX, 63, last valid column.
- Y_MAX, 63, last valid row.
- IMG_WIDTH, 64, pixels per row; must be a power of two, so row offset is a shift.
- BANK_ROWS, 32, rows held per memory bank.
- NUM_BANKS, 2, number of frame-buffer banks; (Y_MAX+1) = NUM_BANKS*BANK_ROWS.
- ADDR_W, 12, bank address width.
- COLOR_W, 12, pixel width.
- CURSOR_SIZE, 2, cursor side S (1..4).
- CURSOR_COLOR, 12'h004, cursor overlay colour.
- BG_COLOR, 12'h000, erase colour.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- ps2_x  in  9  signed cursor X.
- ps2_y  in  9  signed cursor Y.
- pos_valid  in  1  one-cycle strobe: position/buttons valid.
- btn_left  in  1  paint mode while high.
- btn_right  in  1  erase mode while high (left wins if both are high).
- brush_color  in  COLOR_W  paint colour.
- rdata  in  NUM_BANKS*COLOR_W  per-bank read data; bank b occupies slice b; 1-cycle read latency.
- mem_addr  out  ADDR_W  shared read/write address.
- wr_en  out  NUM_BANKS  one-hot bank write strobe.
- wdata  out  COLOR_W  write data.
- busy  out  1  high while an update sequence runs.

Behaviour:
- Reset (asynchronous, active-low): mem_addr=0, wr_en=0, wdata=0, busy=0; state IDLE; have_saved=0; pending=0; save buffer contents don't-care.
- Clamp: a negative coordinate → 0; above the MAX parameter → MAX; otherwise pass through.
- Pixel (px,py) mapping: bank = py / BANK_ROWS; row = py − bank*BANK_ROWS; addr = row*IMG_WIDTH + px.
  - Rows ≥ BANK_ROWS go to the next bank (no off-by-one).
- Cursor origin is the clamped (x,y). Pixel index k = dy*S + dx, with k = 0..S²−1 in raster order.
- A pixel with px > X_MAX or py > Y_MAX is out of range:
  - no read, no write;
  - its cycle is still spent, with wr_en=0.
- Trigger: pos_valid in IDLE starts a sequence if the position differs from the drawn position, or btn_left or btn_right is high. Otherwise it is ignored.
- pos_valid while busy: position and buttons are latched into a one-deep pending register; a newer strobe overwrites it. IDLE services pending on the next cycle.
- Mode: sampled at trigger and held for the whole sequence. PAINT fill = brush_color; ERASE fill = BG_COLOR; none = no fill.
- FSM:
  - IDLE: busy=0; wait for trigger or pending.
  - COMMIT: only in PAINT/ERASE mode with have_saved=1. Overwrites every save-buffer entry with the fill colour, internal only, 1 cycle. The old region's restore therefore writes the fill colour.
  - RESTORE: skipped if have_saved=0. S² cycles; cycle k writes saved[k] to the old pixel k's bank/address.
  - SAVE: issue read k on cycle k. On cycle k+1, capture rdata slice (old bank select, registered) into saved[k]. S²+1 cycles.
  - DRAW: S² cycles. Writes CURSOR_COLOR at the new pixels; in PAINT/ERASE mode it writes the fill colour and also stores it in saved[k].
  - DRAW then updates the old origin to the new one, sets have_saved=1 and returns to IDLE.
- busy is high from the cycle after the trigger through the last DRAW cycle.
- Latency with defaults (S=2, no mode): first move 9 cycles; subsequent moves 13 cycles.
- Writes: a write never coincides with a read of the same cycle's slot. Only the SAVE phase reads.
- Reset mid-sequence: the sequence is aborted immediately and have_saved is cleared; a stale cursor may remain in memory (accepted).

Decomposition:
- Package mouse_paint_pkg:
  - FSM state enum: IDLE, COMMIT, RESTORE, SAVE, DRAW;
  - mode enum: NONE, PAINT, ERASE;
  - clamp function;
  - pixel-to-{bank,addr,in_range} function.
- Sub-module cursor_addr_gen: combinational. Inputs: origin and k. Outputs: bank, addr, in_range. Instantiated once and shared by all phases.

Test Plan:
- Reset, then pos_valid at (10,40), no buttons:
  - no RESTORE phase;
  - SAVE reads bank1 at 522, 523, 586, 587;
  - DRAW writes 12'h004 to those addresses with wr_en=2'b10;
  - busy high for 9 cycles.
- Move to (11,40):
  - RESTORE writes back preloaded values at 522, 523, 586, 587;
  - then SAVE and DRAW at 523, 524, 587, 588;
  - busy high for 13 cycles.
- Origin (63,31):
  - x=64 pixels are skipped (wr_en=0);
  - (63,31) writes bank0 addr 2047; (63,32) writes bank1 addr 63.
- Coordinates ps2_x = −5, ps2_y = 200:
  - clamped to (0,63), bank1 addr 1984;
  - rows 64 and above are skipped.
- btn_left with brush 12'hF00 at (5,5), then move to (20,5) with no buttons: addresses 325, 326, 389, 390 hold 12'hF00, not their original contents.
- Three pos_valid strobes during busy at (1,1), (2,2), (3,3): after the current sequence ends, exactly one sequence runs, to (3,3).

Source files
------------

// File: rtl/mouse_cursor_painter_pkg.sv
// mouse_paint_pkg: shared types and helpers for the mouse cursor painter.
//   state_t    - sequencer states (IDLE, COMMIT, RESTORE, SAVE, DRAW)
//   mode_t     - pointer mode sampled at trigger (NONE, PAINT, ERASE)
//   pix_loc_t  - result of mapping a panel pixel onto a frame-buffer bank
//   clamp_coord() - clamp a signed PS/2 coordinate into 0..max
//   pixel_map()   - (px,py) -> {bank, addr, in_range}
package mouse_paint_pkg;

  // Internal coordinate width; wide enough for origin + cursor offset.
  localparam int COORD_W = 10;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COMMIT  = 3'd1,
    RESTORE = 3'd2,
    SAVE    = 3'd3,
    DRAW    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    PAINT = 2'd1,
    ERASE = 2'd2
  } mode_t;

  // Deliberately wide; the address generator narrows it and treats any
  // nonzero overflow bits as out of range.
  typedef struct packed {
    logic [15:0] bank;
    logic [31:0] addr;
    logic        in_range;
  } pix_loc_t;

  function automatic logic [COORD_W-1:0] clamp_coord(
    input logic signed [8:0] v,
    input int                max_v
  );
    if (v < 9'sd0) return '0;
    if (int'(v) > max_v) return COORD_W'(max_v);
    return COORD_W'(v);
  endfunction

  // Banks hold consecutive row groups. img_width is a power of two, so the
  // row multiply reduces to a shift once the arguments are constants.
  function automatic pix_loc_t pixel_map(
    input logic [COORD_W-1:0] px,
    input logic [COORD_W-1:0] py,
    input int unsigned        x_max,
    input int unsigned        y_max,
    input int unsigned        bank_rows,
    input int unsigned        img_width
  );
    pix_loc_t    loc;
    int unsigned bank_i;
    int unsigned row_i;
    bank_i       = 32'(py) / bank_rows;
    row_i        = 32'(py) - bank_i * bank_rows;
    loc.bank     = 16'(bank_i);
    loc.addr     = row_i * img_width + 32'(px);
    loc.in_range = (32'(px) <= x_max) && (32'(py) <= y_max);
    return loc;
  endfunction

endpackage

// File: rtl/mouse_cursor_painter_addr_gen.sv
// cursor_addr_gen: combinational address generator for cursor pixel k.
//   origin_x/origin_y - clamped cursor origin
//   k                 - raster pixel index inside the S x S cursor
//   bank              - frame-buffer bank holding the pixel
//   addr              - address inside that bank
//   in_range          - pixel lies on the panel (otherwise no access)
module cursor_addr_gen
  import mouse_paint_pkg::*;
#(
  parameter int X_MAX       = 63,
  parameter int Y_MAX       = 63,
  parameter int IMG_WIDTH   = 64,
  parameter int BANK_ROWS   = 32,
  parameter int NUM_BANKS   = 2,
  parameter int ADDR_W      = 12,
  parameter int BANK_W      = 1,
  parameter int CURSOR_SIZE = 2,
  parameter int K_W         = 3
) (
  input  logic [COORD_W-1:0] origin_x,
  input  logic [COORD_W-1:0] origin_y,
  input  logic [K_W-1:0]     k,
  output logic [BANK_W-1:0]  bank,
  output logic [ADDR_W-1:0]  addr,
  output logic               in_range
);

  logic [COORD_W-1:0] px;
  logic [COORD_W-1:0] py;
  pix_loc_t           loc;

  always_comb begin
    px       = origin_x + COORD_W'(32'(k) % CURSOR_SIZE);
    py       = origin_y + COORD_W'(32'(k) / CURSOR_SIZE);
    loc      = pixel_map(px, py, X_MAX, Y_MAX, BANK_ROWS, IMG_WIDTH);
    bank     = BANK_W'(loc.bank);
    addr     = ADDR_W'(loc.addr);
    in_range = loc.in_range
               && (32'(loc.bank) < NUM_BANKS)
               && (64'(loc.addr) < (64'd1 << ADDR_W));
  end

endmodule

// File: rtl/mouse_cursor_painter.sv
// mouse_cursor_painter: draws an S x S cursor into a banked panel frame
// buffer, saving the pixels underneath and restoring them on the next move.
// Left/right buttons turn the cursor into a paint/erase brush.
//   clk, reset       - clock, asynchronous active-low reset
//   ps2_x/ps2_y      - signed cursor position, valid with pos_valid
//   btn_left/right   - paint / erase mode (left wins)
//   brush_color      - paint colour
//   rdata            - per-bank read data, 1-cycle latency, bank b = slice b
//   mem_addr         - shared bank address
//   wr_en            - one-hot bank write strobe
//   wdata            - write data
//   busy             - update sequence in progress
module mouse_cursor_painter
  import mouse_paint_pkg::*;
#(
  parameter int              X_MAX        = 63,
  parameter int              Y_MAX        = 63,
  parameter int              IMG_WIDTH    = 64,
  parameter int              BANK_ROWS    = 32,
  parameter int              NUM_BANKS    = 2,
  parameter int              ADDR_W       = 12,
  parameter int              COLOR_W      = 12,
  parameter int              CURSOR_SIZE  = 2,
  parameter logic [COLOR_W-1:0] CURSOR_COLOR = 12'h004,
  parameter logic [COLOR_W-1:0] BG_COLOR     = 12'h000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic signed [8:0]            ps2_x,
  input  logic signed [8:0]            ps2_y,
  input  logic                         pos_valid,
  input  logic                         btn_left,
  input  logic                         btn_right,
  input  logic [COLOR_W-1:0]           brush_color,
  input  logic [NUM_BANKS*COLOR_W-1:0] rdata,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [NUM_BANKS-1:0]         wr_en,
  output logic [COLOR_W-1:0]           wdata,
  output logic                         busy
);

  localparam int NPIX       = CURSOR_SIZE * CURSOR_SIZE;
  // SAVE counts one extra slot (0..NPIX) to collect the last read.
  localparam int K_W        = $clog2(NPIX + 1);
  localparam int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1;
  localparam int BANK_SLOTS = 1 << BANK_W;
  localparam logic [K_W-1:0] K_LAST = K_W'(NPIX - 1);
  localparam logic [K_W-1:0] K_NPIX = K_W'(NPIX);

  state_t              state_reg;
  logic [K_W-1:0]      cnt_reg;
  logic                have_saved_reg;
  mode_t               mode_reg;
  logic [COLOR_W-1:0]  fill_reg;
  logic [COORD_W-1:0]  new_x_reg, new_y_reg, old_x_reg, old_y_reg;
  logic                pend_valid_reg, pend_left_reg, pend_right_reg;
  logic signed [8:0]   pend_x_reg, pend_y_reg;
  logic [COLOR_W-1:0]  pend_color_reg;
  logic                cap_valid_reg;
  logic [BANK_W-1:0]   cap_bank_reg;
  logic [K_W-1:0]      cap_idx_reg;
  logic [COLOR_W-1:0]  saved_reg [0:(1<<K_W)-1];

  // Unpack the flat read bus; padding slots only exist for non-power-of-two
  // bank counts and are never selected.
  logic [COLOR_W-1:0] rdata_bank [0:BANK_SLOTS-1];
  genvar gi;
  for (gi = 0; gi < BANK_SLOTS; gi++) begin : g_rdata
    if (gi < NUM_BANKS) begin : g_real
      assign rdata_bank[gi] = rdata[gi*COLOR_W +: COLOR_W];
    end else begin : g_pad
      assign rdata_bank[gi] = '0;
    end
  end

  // Candidate request: a live strobe takes precedence over the pending one.
  logic signed [8:0]  src_x, src_y;
  logic               src_left, src_right;
  logic [COLOR_W-1:0] src_color;
  logic [COORD_W-1:0] cand_x, cand_y;
  mode_t              cand_mode;
  logic               trigger;

  always_comb begin
    src_x     = pos_valid ? ps2_x       : pend_x_reg;
    src_y     = pos_valid ? ps2_y       : pend_y_reg;
    src_left  = pos_valid ? btn_left    : pend_left_reg;
    src_right = pos_valid ? btn_right   : pend_right_reg;
    src_color = pos_valid ? brush_color : pend_color_reg;
    cand_x    = clamp_coord(src_x, X_MAX);
    cand_y    = clamp_coord(src_y, Y_MAX);
    cand_mode = src_left ? PAINT : (src_right ? ERASE : NONE);
    trigger   = (state_reg == IDLE) && (pos_valid || pend_valid_reg)
                && (!have_saved_reg || cand_x != old_x_reg
                    || cand_y != old_y_reg || cand_mode != NONE);
  end

  // One generator serves every phase; RESTORE walks the old origin.
  logic [BANK_W-1:0] ag_bank;
  logic [ADDR_W-1:0] ag_addr;
  logic              ag_in_range;

  cursor_addr_gen #(
    .X_MAX(X_MAX), .Y_MAX(Y_MAX), .IMG_WIDTH(IMG_WIDTH), .BANK_ROWS(BANK_ROWS),
    .NUM_BANKS(NUM_BANKS), .ADDR_W(ADDR_W), .BANK_W(BANK_W),
    .CURSOR_SIZE(CURSOR_SIZE), .K_W(K_W)
  ) u_addr_gen (
    .origin_x (state_reg == RESTORE ? old_x_reg : new_x_reg),
    .origin_y (state_reg == RESTORE ? old_y_reg : new_y_reg),
    .k        (cnt_reg),
    .bank     (ag_bank),
    .addr     (ag_addr),
    .in_range (ag_in_range)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= '0;
      have_saved_reg <= 1'b0;
      mode_reg       <= NONE;
      fill_reg       <= '0;
      new_x_reg      <= '0;
      new_y_reg      <= '0;
      old_x_reg      <= '0;
      old_y_reg      <= '0;
      pend_valid_reg <= 1'b0;
      pend_left_reg  <= 1'b0;
      pend_right_reg <= 1'b0;
      pend_x_reg     <= '0;
      pend_y_reg     <= '0;
      pend_color_reg <= '0;
      cap_valid_reg  <= 1'b0;
      cap_bank_reg   <= '0;
      cap_idx_reg    <= '0;
    end else begin
      // Read issued in SAVE slot k returns next cycle; remember where it goes.
      cap_valid_reg <= (state_reg == SAVE) && (cnt_reg != K_NPIX) && ag_in_range;
      cap_bank_reg  <= ag_bank;
      cap_idx_reg   <= cnt_reg;

      if (state_reg != IDLE && pos_valid) begin
        pend_valid_reg <= 1'b1;
        pend_x_reg     <= ps2_x;
        pend_y_reg     <= ps2_y;
        pend_left_reg  <= btn_left;
        pend_right_reg <= btn_right;
        pend_color_reg <= brush_color;
      end else if (state_reg == IDLE) begin
        pend_valid_reg <= 1'b0;
      end

      case (state_reg)
        IDLE: begin
          if (trigger) begin
            new_x_reg <= cand_x;
            new_y_reg <= cand_y;
            mode_reg  <= cand_mode;
            fill_reg  <= (cand_mode == PAINT) ? src_color : BG_COLOR;
            cnt_reg   <= '0;
            if (!have_saved_reg)        state_reg <= SAVE;
            else if (cand_mode != NONE) state_reg <= COMMIT;
            else                        state_reg <= RESTORE;
          end
        end
        COMMIT: state_reg <= RESTORE;
        RESTORE: begin
          if (cnt_reg == K_LAST) begin
            cnt_reg   <= '0;
            state_reg <= SAVE;
          end else begin
            cnt_reg <= cnt_reg + K_W'(1);
          end
        end
        SAVE: begin
          if (cnt_reg == K_NPIX) begin
            cnt_reg   <= '0;
            state_reg <= DRAW;
          end else begin
            cnt_reg <= cnt_reg + K_W'(1);
          end
        end
        DRAW: begin
          if (cnt_reg == K_LAST) begin
            cnt_reg        <= '0;
            old_x_reg      <= new_x_reg;
            old_y_reg      <= new_y_reg;
            have_saved_reg <= 1'b1;
            state_reg      <= IDLE;
          end else begin
            cnt_reg <= cnt_reg + K_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Save buffer: COMMIT turns the old region into fill colour; in a brush
  // mode DRAW also records the fill so the next restore keeps the paint.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NPIX; i++) begin
      if (state_reg == COMMIT)
        saved_reg[i] <= fill_reg;
      else if (cap_valid_reg && cap_idx_reg == K_W'(i))
        saved_reg[i] <= rdata_bank[cap_bank_reg];
      else if (state_reg == DRAW && mode_reg != NONE && cnt_reg == K_W'(i))
        saved_reg[i] <= fill_reg;
    end
  end

  always_comb begin
    mem_addr = '0;
    wr_en    = '0;
    wdata    = '0;
    case (state_reg)
      RESTORE: if (ag_in_range) begin
        mem_addr = ag_addr;
        wr_en    = NUM_BANKS'(1) << ag_bank;
        wdata    = saved_reg[cnt_reg];
      end
      SAVE: if (cnt_reg != K_NPIX && ag_in_range) begin
        mem_addr = ag_addr;
      end
      DRAW: if (ag_in_range) begin
        mem_addr = ag_addr;
        wr_en    = NUM_BANKS'(1) << ag_bank;
        wdata    = (mode_reg == NONE) ? CURSOR_COLOR : fill_reg;
      end
      default: ;
    endcase
  end

  assign busy = (state_reg != IDLE);

endmodule

// File: tb/tb_mouse_cursor_painter.sv
// Directed bench for mouse_cursor_painter with a two-bank frame-buffer model
// (1-cycle read latency). Each move logs the writes seen while busy and
// compares them with hand-computed lists.
module tb_mouse_cursor_painter;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic signed [8:0] ps2_x = '0;
  logic signed [8:0] ps2_y = '0;
  logic              pos_valid = 1'b0;
  logic              btn_left = 1'b0;
  logic              btn_right = 1'b0;
  logic [11:0]       brush_color = '0;
  logic [23:0]       rdata;
  logic [11:0]       mem_addr;
  logic [1:0]        wr_en;
  logic [11:0]       wdata;
  logic              busy;

  always #5 clk = ~clk;

  mouse_cursor_painter dut (
    .clk(clk), .reset(reset), .ps2_x(ps2_x), .ps2_y(ps2_y),
    .pos_valid(pos_valid), .btn_left(btn_left), .btn_right(btn_right),
    .brush_color(brush_color), .rdata(rdata), .mem_addr(mem_addr),
    .wr_en(wr_en), .wdata(wdata), .busy(busy)
  );

  // Frame-buffer model.
  logic        load_mem = 1'b1;
  logic [11:0] mem [0:1][0:4095];
  logic [11:0] rq [0:1];
  assign rdata = {rq[1], rq[0]};

  function automatic logic [11:0] pat(input int b, input int a);
    return 12'((a * 37 + b * 1001 + 5) % 4096);
  endfunction

  always @(posedge clk) begin
    if (load_mem) begin
      for (int b = 0; b < 2; b++)
        for (int a = 0; a < 4096; a++)
          mem[b][a] <= pat(b, a);
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (wr_en[b]) mem[b][mem_addr] <= wdata;
        rq[b] <= mem[b][mem_addr];
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ent(input int b, input int a, input logic [11:0] d);
    return {4'(b), 4'h0, 12'(a), d};
  endfunction

  logic [31:0] wlog[$];
  logic [31:0] rlog[$];
  logic [31:0] expq[$];
  int          busy_cnt;
  int          rises;

  function automatic logic [31:0] log_write();
    int b;
    b = (wr_en == 2'b01) ? 0 : (wr_en == 2'b10) ? 1 : 15;
    return ent(b, int'(mem_addr), wdata);
  endfunction

  // Strobe one request at a negedge and follow the DUT until it is idle again.
  task automatic move(input string tag, input int x, input int y,
                      input logic l, input logic r, input logic [11:0] col);
    int seen;
    seen = 0;
    wlog.delete();
    rlog.delete();
    busy_cnt = 0;
    ps2_x = 9'(x); ps2_y = 9'(y); btn_left = l; btn_right = r;
    brush_color = col; pos_valid = 1'b1;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      pos_valid = 1'b0; btn_left = 1'b0; btn_right = 1'b0;
      if (busy) begin
        busy_cnt++;
        seen = 1;
        if (wr_en != 2'b00) wlog.push_back(log_write());
        else rlog.push_back(32'(mem_addr));
      end
      if (!busy && (seen != 0 || c >= 8)) break;
    end
    check({tag, " idle"}, 32'(busy), 32'd0);
    $display("[TB] %s: move to (%0d,%0d) l=%0b r=%0b busy=%0d writes=%0d",
             tag, x, y, l, r, busy_cnt, wlog.size());
  endtask

  task automatic cmp_writes(input string tag);
    check({tag, " nwr"}, 32'(wlog.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size(); i++)
      check($sformatf("%s wr%0d", tag, i),
            (i < wlog.size()) ? wlog[i] : 32'hDEAD_BEEF, expq[i]);
    expq.delete();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    load_mem = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset wr_en", 32'(wr_en), 32'd0);
    check("reset addr", 32'(mem_addr), 32'd0);
    check("reset wdata", 32'(wdata), 32'd0);

    // First move: no restore, SAVE + DRAW only.
    move("t1", 10, 40, 0, 0, 12'h0);
    check("t1 busy", 32'(busy_cnt), 32'd9);
    check("t1 rd0", rlog.size() > 0 ? rlog[0] : 32'hFFFF, 32'd522);
    check("t1 rd1", rlog.size() > 1 ? rlog[1] : 32'hFFFF, 32'd523);
    check("t1 rd2", rlog.size() > 2 ? rlog[2] : 32'hFFFF, 32'd586);
    check("t1 rd3", rlog.size() > 3 ? rlog[3] : 32'hFFFF, 32'd587);
    expq = '{ent(1,522,12'h004), ent(1,523,12'h004), ent(1,586,12'h004), ent(1,587,12'h004)};
    cmp_writes("t1");

    // One-pixel move: restore originals, then draw at the new spot.
    move("t2", 11, 40, 0, 0, 12'h0);
    check("t2 busy", 32'(busy_cnt), 32'd13);
    expq = '{ent(1,522,pat(1,522)), ent(1,523,pat(1,523)), ent(1,586,pat(1,586)),
             ent(1,587,pat(1,587)), ent(1,523,12'h004), ent(1,524,12'h004),
             ent(1,587,12'h004), ent(1,588,12'h004)};
    cmp_writes("t2");

    // Right-edge / bank-boundary origin.
    move("t3", 63, 31, 0, 0, 12'h0);
    check("t3 busy", 32'(busy_cnt), 32'd13);
    expq = '{ent(1,523,pat(1,523)), ent(1,524,pat(1,524)), ent(1,587,pat(1,587)),
             ent(1,588,pat(1,588)), ent(0,2047,12'h004), ent(1,63,12'h004)};
    cmp_writes("t3");

    // Clamped to (0,63); row 64 is skipped.
    move("t4", -5, 200, 0, 0, 12'h0);
    check("t4 busy", 32'(busy_cnt), 32'd13);
    expq = '{ent(0,2047,pat(0,2047)), ent(1,63,pat(1,63)),
             ent(1,1984,12'h004), ent(1,1985,12'h004)};
    cmp_writes("t4");

    // Paint: commit turns the old cursor area into brush colour too.
    move("t5", 5, 5, 1, 0, 12'hF00);
    check("t5 busy", 32'(busy_cnt), 32'd14);
    expq = '{ent(1,1984,12'hF00), ent(1,1985,12'hF00), ent(0,325,12'hF00),
             ent(0,326,12'hF00), ent(0,389,12'hF00), ent(0,390,12'hF00)};
    cmp_writes("t5");

    move("t6", 20, 5, 0, 0, 12'h0);
    check("t6 busy", 32'(busy_cnt), 32'd13);
    expq = '{ent(0,325,12'hF00), ent(0,326,12'hF00), ent(0,389,12'hF00),
             ent(0,390,12'hF00), ent(0,340,12'h004), ent(0,341,12'h004),
             ent(0,404,12'h004), ent(0,405,12'h004)};
    cmp_writes("t6");
    check("t6 mem325", 32'(mem[0][325]), 32'hF00);
    check("t6 mem390", 32'(mem[0][390]), 32'hF00);
    check("t6 mem1984", 32'(mem[1][1984]), 32'hF00);

    // Same position, no buttons: ignored.
    move("t7", 20, 5, 0, 0, 12'h0);
    check("t7 busy", 32'(busy_cnt), 32'd0);
    cmp_writes("t7");

    // Three strobes while busy collapse into one follow-up sequence.
    wlog.delete();
    busy_cnt = 0;
    rises = 0;
    begin
      logic prev_busy;
      prev_busy = 1'b0;
      ps2_x = 9'd30; ps2_y = 9'd10; pos_valid = 1'b1;
      for (int c = 0; c < 80; c++) begin
        @(negedge clk);
        if (busy && !prev_busy) rises++;
        prev_busy = busy;
        if (busy) busy_cnt++;
        if (wr_en != 2'b00) wlog.push_back(log_write());
        case (c)
          2: begin ps2_x = 9'd1; ps2_y = 9'd1; pos_valid = 1'b1; end
          3: begin ps2_x = 9'd2; ps2_y = 9'd2; end
          4: begin ps2_x = 9'd3; ps2_y = 9'd3; end
          default: pos_valid = 1'b0;
        endcase
        if (c > 40 && !busy) break;
      end
    end
    $display("[TB] t8: pending strobes busy=%0d sequences=%0d writes=%0d",
             busy_cnt, rises, wlog.size());
    check("t8 idle", 32'(busy), 32'd0);
    check("t8 seqs", 32'(rises), 32'd2);
    check("t8 busy", 32'(busy_cnt), 32'd26);
    check("t8 nwr", 32'(wlog.size()), 32'd16);
    if (wlog.size() == 16) begin
      check("t8 wr12", wlog[12], ent(0,195,12'h004));
      check("t8 wr13", wlog[13], ent(0,196,12'h004));
      check("t8 wr14", wlog[14], ent(0,259,12'h004));
      check("t8 wr15", wlog[15], ent(0,260,12'h004));
    end

    // Erase at the current position: button alone triggers.
    move("t9", 3, 3, 0, 1, 12'h0);
    check("t9 busy", 32'(busy_cnt), 32'd14);
    expq = '{ent(0,195,12'h000), ent(0,196,12'h000), ent(0,259,12'h000),
             ent(0,260,12'h000), ent(0,195,12'h000), ent(0,196,12'h000),
             ent(0,259,12'h000), ent(0,260,12'h000)};
    cmp_writes("t9");
    check("t9 mem195", 32'(mem[0][195]), 32'h000);

    // Asynchronous reset mid-sequence, then first-move timing again.
    ps2_x = 9'd50; ps2_y = 9'd50; pos_valid = 1'b1;
    @(negedge clk);
    pos_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("t10 pre busy", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("t10 rst busy", 32'(busy), 32'd0);
    check("t10 rst wr_en", 32'(wr_en), 32'd0);
    check("t10 rst addr", 32'(mem_addr), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    $display("[TB] t10: reset asserted mid-sequence");
    move("t11", 40, 20, 0, 0, 12'h0);
    check("t11 busy", 32'(busy_cnt), 32'd9);
    expq = '{ent(0,1320,12'h004), ent(0,1321,12'h004), ent(0,1384,12'h004), ent(0,1385,12'h004)};
    cmp_writes("t11");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
